ps2_host_ctrl: RTL and testbench

- Host-side PS/2 command sequencer. Sends command bytes to the keyboard (0xED set-LEDs + argument, 0xFF reset, 0xF4 enable), then collects and checks the device response (ACK 0xFA, resend 0xFE, error 0xFC).
- Shares the PS/2 line with the scancode receive path: unsolicited bytes pass through on rx_valid/rx_byte only while no command is in flight.
- Sits between the keyboard pins (open-drain) and the scancode parser / LED-state logic.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_frame_rx.sv | 59 +++++
 rtl/ps2_host_ctrl.sv | 173 +++++++++++++++++
 tb/tb_ps2_host_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 command/response codes, error codes, FSM states and frame helper
package ps2_pkg;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_ERR      = 8'hFC;
  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
  localparam logic [1:0] ERR_RETRY    = 2'd2;
  localparam logic [1:0] ERR_FRAME    = 2'd3;
  typedef enum logic [2:0] {IDLE, INHIBIT, RELEASE, TX, TX_ACK, RX_RESP, CHECK} state_e;
  function automatic logic [9:0] tx_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction
endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronize PS/2 pins, detect clock falls, shift and validate 11-bit frames
module ps2_frame_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  input  logic       en,
  input  logic       clr,
  output logic       fall,
  output logic       data_s,
  output logic       done,
  output logic [7:0] rx_byte,
  output logic       good,
  output logic       idle
);
  logic [1:0] csync_q, csync_d, dsync_q, dsync_d;
  logic cprev_q, cprev_d, done_q, done_d;
  logic [10:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  assign fall = cprev_q & ~csync_q[1];
  assign data_s = dsync_q[1];
  assign done = done_q;
  assign rx_byte = sr_q[8:1];
  assign good = ~sr_q[0] & sr_q[10] & ^sr_q[9:1];
  assign idle = cnt_q == 4'd0;
  // Synchronize pins and shift one bit per fall; a clear beats an edge in the same cycle
  always_comb begin
    csync_d = {csync_q[0], ps2clk_i};
    dsync_d = {dsync_q[0], ps2data_i};
    cprev_d = csync_q[1];
    sr_d = sr_q;
    cnt_d = cnt_q;
    done_d = 1'b0;
    if (clr) cnt_d = 4'd0;
    else if (en && fall) begin
      sr_d = {dsync_q[1], sr_q[10:1]};
      cnt_d = cnt_q == 4'd10 ? 4'd0 : cnt_q + 4'd1;
      done_d = cnt_q == 4'd10;
    end
  end
  // Registers; synchronizers reset to the idle-high line level so reset makes no false edge
  always_ff @(posedge clk) begin
    if (rst) begin
      csync_q <= 2'b11;
      dsync_q <= 2'b11;
      cprev_q <= 1'b1;
      sr_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      csync_q <= csync_d;
      dsync_q <= dsync_d;
      cprev_q <= cprev_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      done_q <= done_d;
    end
  end
endmodule

// File: rtl/ps2_host_ctrl.sv
// ps2_host_ctrl: PS/2 host command sequencer with response check and unsolicited byte pass-through
module ps2_host_ctrl import ps2_pkg::*; #(
  parameter int INHIBIT_CYC = 5000,
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk_i,
  input  logic       ps2data_i,
  output logic       ps2clk_oe,
  output logic       ps2data_oe,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [7:0] cmd_byte,
  input  logic       cmd_arg_en,
  input  logic [7:0] cmd_arg,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code,
  output logic       rx_valid,
  output logic [7:0] rx_byte
);
  localparam int TW = $clog2((TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC) + 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  state_e state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, rx_byte_q, rx_byte_d, fr_byte;
  logic [1:0] err_code_q, err_code_d, fail_code;
  logic sel_q, sel_d, arg_en_q, arg_en_d, data_oe_q, data_oe_d;
  logic done_q, done_d, err_q, err_d, rx_valid_q, rx_valid_d;
  logic fall, data_s, fr_done, fr_good, fr_idle, accept, active, resend, fail, rx_clr;
  logic [9:0] tx_bits;
  assign cmd_ready = state_q == IDLE && fr_idle;
  assign accept = cmd_valid && cmd_ready;
  assign busy = state_q != IDLE;
  assign active = state_q inside {RELEASE, TX, TX_ACK, RX_RESP};
  assign tx_bits = tx_frame(sel_q ? arg_q : cmd_q);
  assign rx_clr = accept || (state_q != IDLE && state_d == IDLE);
  assign ps2clk_oe = state_q == INHIBIT;
  assign ps2data_oe = data_oe_q;
  assign done = done_q;
  assign err = err_q;
  assign err_code = err_code_q;
  assign rx_valid = rx_valid_q;
  assign rx_byte = rx_byte_q;
  ps2_frame_rx u_rx (
    .clk(clk), .rst(rst), .ps2clk_i(ps2clk_i), .ps2data_i(ps2data_i),
    .en(state_q == IDLE || state_q == RX_RESP), .clr(rx_clr),
    .fall(fall), .data_s(data_s), .done(fr_done), .rx_byte(fr_byte), .good(fr_good), .idle(fr_idle)
  );
  // Command FSM: next state, line drive, retry/timeout accounting and result pulses
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    sel_d = sel_q;
    retry_d = retry_q;
    data_oe_d = data_oe_q;
    cmd_d = cmd_q;
    arg_d = arg_q;
    arg_en_d = arg_en_q;
    done_d = 1'b0;
    err_d = 1'b0;
    err_code_d = ERR_NONE;
    rx_valid_d = state_q == IDLE && fr_done && fr_good;
    rx_byte_d = rx_valid_d ? fr_byte : rx_byte_q;
    resend = 1'b0;
    fail = 1'b0;
    fail_code = ERR_NONE;
    case (state_q)
      IDLE: if (accept) begin
        cmd_d = cmd_byte;
        arg_d = cmd_arg;
        arg_en_d = cmd_arg_en;
        sel_d = 1'b0;
        retry_d = '0;
        state_d = INHIBIT;
      end
      INHIBIT: if (tmo_q == TW'(INHIBIT_CYC - 1)) begin
        data_oe_d = 1'b1;
        idx_d = 4'd0;
        state_d = RELEASE;
      end
      RELEASE: state_d = TX;
      TX: if (fall) begin
        data_oe_d = ~tx_bits[idx_q];
        idx_d = idx_q + 4'd1;
        state_d = idx_q == 4'd9 ? TX_ACK : TX;
      end
      TX_ACK: if (fall) begin
        resend = data_s;
        state_d = RX_RESP;
      end
      RX_RESP: if (fr_done) state_d = CHECK;
      CHECK: begin
        if (!fr_good) begin
          fail = 1'b1;
          fail_code = ERR_FRAME;
        end else if (fr_byte == RSP_ACK) begin
          if (!sel_q && arg_en_q) begin
            sel_d = 1'b1;
            retry_d = '0;
            state_d = INHIBIT;
          end else begin
            done_d = 1'b1;
            state_d = IDLE;
          end
        end else if (fr_byte == RSP_RESEND) resend = 1'b1;
        else begin
          fail = 1'b1;
          fail_code = fr_byte == RSP_ERR ? ERR_RETRY : ERR_FRAME;
        end
      end
      default: state_d = IDLE;
    endcase
    if (resend) begin
      retry_d = retry_q + RW'(1);
      state_d = INHIBIT;
      if (retry_q >= RW'(MAX_RETRY)) begin
        fail = 1'b1;
        fail_code = ERR_RETRY;
      end
    end
    if (active && !fall && tmo_q == TW'(TIMEOUT_CYC - 1)) begin
      fail = 1'b1;
      fail_code = ERR_TIMEOUT;
    end
    if (fail) begin
      err_d = 1'b1;
      err_code_d = fail_code;
      state_d = IDLE;
    end
    if (state_d == IDLE) data_oe_d = 1'b0;
    tmo_d = (state_d != state_q || (active && fall)) ? '0 : tmo_q + TW'(1);
  end
  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tmo_q <= '0;
      retry_q <= '0;
      idx_q <= '0;
      sel_q <= 1'b0;
      cmd_q <= '0;
      arg_q <= '0;
      arg_en_q <= 1'b0;
      data_oe_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      err_code_q <= ERR_NONE;
      rx_valid_q <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      state_q <= state_d;
      tmo_q <= tmo_d;
      retry_q <= retry_d;
      idx_q <= idx_d;
      sel_q <= sel_d;
      cmd_q <= cmd_d;
      arg_q <= arg_d;
      arg_en_q <= arg_en_d;
      data_oe_q <= data_oe_d;
      done_q <= done_d;
      err_q <= err_d;
      err_code_q <= err_code_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q <= rx_byte_d;
    end
  end
endmodule

// File: tb/tb_ps2_host_ctrl.sv
// tb_ps2_host_ctrl: directed bench with an open-drain keyboard model for ps2_host_ctrl
`timescale 1ns/1ps
module tb_ps2_host_ctrl;
  localparam int INH = 500;
  localparam int TMO = 3000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2clk_oe, ps2data_oe, cmd_ready, busy, done, err, rx_valid;
  logic [1:0] err_code;
  logic [7:0] rx_byte;
  logic cmd_valid = 1'b0;
  logic cmd_arg_en = 1'b0;
  logic [7:0] cmd_byte = '0;
  logic [7:0] cmd_arg = '0;
  logic dev_clk_low = 1'b0;
  logic dev_data_low = 1'b0;
  logic ps2clk_pin, ps2data_pin;
  int cyc = 0, n_chk = 0, n_fail = 0, n_done = 0, n_err = 0, n_rx = 0, n_acc = 0, n_inh = 0, n_busy = 0;
  int err_cyc = 0, last_fall = 0, dev_bits = 0;
  logic [1:0] last_code = '0;
  logic [7:0] last_rx = '0;
  logic clk_oe_prev = 1'b0;
  assign ps2clk_pin = ~(ps2clk_oe | dev_clk_low);
  assign ps2data_pin = ~(ps2data_oe | dev_data_low);
  always #5 clk = ~clk;
  ps2_host_ctrl #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .ps2clk_i(ps2clk_pin), .ps2data_i(ps2data_pin),
    .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_arg_en(cmd_arg_en), .cmd_arg(cmd_arg), .busy(busy), .done(done),
    .err(err), .err_code(err_code), .rx_valid(rx_valid), .rx_byte(rx_byte)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (done === 1'b1) n_done++;
    if (err === 1'b1) begin
      n_err++;
      last_code = err_code;
      err_cyc = cyc;
    end
    if (rx_valid === 1'b1) begin
      n_rx++;
      last_rx = rx_byte;
    end
    if (busy === 1'b1) n_busy++;
    if (cmd_valid && cmd_ready === 1'b1) n_acc++;
    if (ps2clk_oe === 1'b1 && !clk_oe_prev) n_inh++;
    clk_oe_prev = ps2clk_oe === 1'b1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic dev_send(input logic [7:0] b, input logic flip);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_data_low = ~f[i];
      repeat (5) @(negedge clk);
      dev_clk_low = 1'b1;
      dev_bits++;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
    end
    dev_data_low = 1'b0;
    repeat (20) @(negedge clk);
  endtask
  task automatic dev_recv(input int nclk, output logic [9:0] bits, output int inh);
    int to;
    bits = '0;
    inh = 0;
    to = 0;
    while (ps2clk_oe !== 1'b1 && to < 20000) begin
      @(negedge clk);
      to++;
    end
    check("inhibit_seen", ps2clk_oe, 1);
    while (ps2clk_oe === 1'b1 && inh < 100000) begin
      inh++;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("start_bit", ps2data_pin, 0);
    for (int i = 0; i < nclk; i++) begin
      dev_clk_low = 1'b1;
      last_fall = cyc;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      bits[i] = ps2data_pin;
      repeat (10) @(negedge clk);
    end
    if (nclk == 10) begin
      dev_data_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (10) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      dev_data_low = 1'b0;
      repeat (10) @(negedge clk);
    end
  endtask
  task automatic send_cmd(input logic [7:0] b, input logic ae, input logic [7:0] a);
    int to;
    to = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte = b;
    cmd_arg_en = ae;
    cmd_arg = a;
    while (cmd_ready !== 1'b1 && to < 2000) begin
      @(negedge clk);
      to++;
    end
    check("cmd_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wait_end(input int s0, input int lim);
    int to;
    to = 0;
    while (n_done + n_err == s0 && to < lim) begin
      @(posedge clk);
      to++;
    end
    check("end_event", n_done + n_err != s0, 1);
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    logic [9:0] bits;
    int inh, s0, r0, i0, a0, d0, b0, e0, to;
    repeat (4) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_oe", {ps2clk_oe, ps2data_oe}, 0);
    check("rst_pulses", {done, err, rx_valid}, 0);
    check("rst_err_code", err_code, 0);
    check("rst_rx_byte", rx_byte, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    // unsolicited good frame then the same byte with parity flipped
    r0 = n_rx;
    b0 = n_busy;
    dev_send(8'h1D, 1'b0);
    check("rx_good_count", n_rx - r0, 1);
    check("rx_good_byte", last_rx, 8'h1D);
    dev_send(8'h1D, 1'b1);
    check("rx_badpar_count", n_rx - r0, 1);
    check("rx_busy_idle", n_busy - b0, 0);
    // 0xF4 enable, acknowledged
    s0 = n_done + n_err;
    d0 = n_done;
    e0 = n_err;
    r0 = n_rx;
    send_cmd(8'hF4, 1'b0, 8'h00);
    dev_recv(10, bits, inh);
    check("f4_inhibit_len", inh, INH);
    check("f4_bits", bits, 10'h2F4);
    dev_send(8'hFA, 1'b0);
    wait_end(s0, 2000);
    repeat (2) @(posedge clk);
    check("f4_done", n_done - d0, 1);
    check("f4_no_err", n_err - e0, 0);
    check("f4_no_rx", n_rx - r0, 0);
    // 0xED + 0x02, two acknowledged bytes, competing request held off
    s0 = n_done + n_err;
    d0 = n_done;
    i0 = n_inh;
    send_cmd(8'hED, 1'b1, 8'h02);
    check("ed_ready_busy", cmd_ready, 0);
    a0 = n_acc;
    cmd_valid = 1'b1;
    cmd_byte = 8'hFF;
    cmd_arg_en = 1'b0;
    dev_recv(10, bits, inh);
    check("ed_bits", bits, 10'h3ED);
    dev_send(8'hFA, 1'b0);
    dev_recv(10, bits, inh);
    check("ed_arg_bits", bits, 10'h202);
    cmd_valid = 1'b0;
    check("ed_no_accept_busy", n_acc - a0, 0);
    dev_send(8'hFA, 1'b0);
    wait_end(s0, 2000);
    repeat (2) @(posedge clk);
    check("ed_single_done", n_done - d0, 1);
    check("ed_two_tx", n_inh - i0, 2);
    // 0xFF answered by 0xFE four times
    s0 = n_done + n_err;
    d0 = n_done;
    i0 = n_inh;
    send_cmd(8'hFF, 1'b0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      dev_recv(10, bits, inh);
      check("ff_bits", bits, 10'h3FF);
      dev_send(8'hFE, 1'b0);
    end
    wait_end(s0, 2000);
    repeat (2) @(posedge clk);
    check("ff_err_code", last_code, 2);
    check("ff_no_done", n_done - d0, 0);
    repeat (1000) @(posedge clk);
    check("ff_four_tx", n_inh - i0, 4);
    check("ff_idle_after", busy, 0);
    // device stops clocking after data bit 3
    s0 = n_done + n_err;
    send_cmd(8'hF4, 1'b0, 8'h00);
    dev_recv(4, bits, inh);
    check("tmo_bits", bits[3:0], 4'b0100);
    wait_end(s0, TMO + 500);
    repeat (2) @(posedge clk);
    check("tmo_err_code", last_code, 1);
    // pin fall -> two synchronizer stages + registered err pulse adds three cycles
    check("tmo_latency", err_cyc - last_fall, TMO + 3);
    check("tmo_oe_released", {ps2clk_oe, ps2data_oe}, 0);
    // request during a partial incoming frame, then reset mid-transmit
    r0 = n_rx;
    dev_bits = 0;
    fork
      dev_send(8'h1C, 1'b0);
    join_none
    repeat (110) @(negedge clk);
    check("midframe_not_ready", cmd_ready, 0);
    cmd_valid = 1'b1;
    cmd_byte = 8'hF4;
    cmd_arg_en = 1'b0;
    to = 0;
    while (cmd_ready !== 1'b1 && to < 1000) begin
      @(negedge clk);
      to++;
    end
    check("ready_after_frame", dev_bits, 11);
    check("ready_now", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    check("midframe_rx_count", n_rx - r0, 1);
    check("midframe_rx_byte", last_rx, 8'h1C);
    dev_recv(4, bits, inh);
    check("midtx_data_driven", ps2data_oe, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_midtx_oe", {ps2clk_oe, ps2data_oe}, 0);
    check("rst_midtx_ready", cmd_ready, 1);
    check("rst_midtx_busy", busy, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
